rle_encode: RTL
===============

RLE_ENCODE -- requirements
Module: rle_encode

Interface
REQ-001 Param data_width_p, default 2, pixel value width.
REQ-002 Param bus_width_p, default 8, packed run-token width.
REQ-003 Param count_width_p, default bus_width_p - data_width_p, run-length field width.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 data_i  input  data_width_p  pixel value.
REQ-007 last_i  input  1  marks final pixel of frame; qualified by valid_i.
REQ-008 valid_i  input  1  upstream pixel valid.
REQ-009 ready_o  output  1  block accepts pixel this cycle.
REQ-010 rle_value_o  output  data_width_p  run value.
REQ-011 rle_count_o  output  count_width_p  run length, 1..2^count_width_p-1.
REQ-012 valid_o  output  1  run token valid.
REQ-013 ready_i  input  1  downstream (rle_decode) accepts token.

Function
REQ-014 Input fire = valid_i && ready_o; output fire = valid_o && ready_i.
REQ-015 Internal: accumulator (acc_value_r, acc_count_r); one-entry output register (value, count, valid); state EMPTY, RUN, FLUSH.
REQ-016 CMAX = 2^count_width_p - 1 (63 at defaults); acc_count_r never exceeds CMAX, never wraps.
REQ-017 ready_o = (state != FLUSH) && (!valid_o || ready_i); combinational, no dependence on valid_i.
REQ-018 EMPTY, fire, !last_i: acc <= (data_i, 1); -> RUN.
REQ-019 EMPTY, fire, last_i: output <= (data_i, 1); stay EMPTY.
REQ-020 RUN, fire, data_i == acc_value_r and acc_count_r < CMAX, !last_i: acc_count_r += 1; stay RUN.
REQ-021 RUN, fire, match and not saturated, last_i: output <= (acc_value_r, acc_count_r+1); acc cleared; -> EMPTY.
REQ-022 RUN, fire, mismatch or acc_count_r == CMAX, !last_i: output <= (acc_value_r, acc_count_r); acc <= (data_i, 1); stay RUN.
REQ-023 RUN, fire, mismatch or saturated, last_i: output <= old acc; acc <= (data_i, 1); -> FLUSH.
REQ-024 FLUSH: when output register empty or output fire, output <= acc; acc cleared; -> EMPTY; ready_o low throughout FLUSH.
REQ-025 Latency: token valid_o asserts cycle after the terminating input fire (or FLUSH transfer); no combinational path data_i -> outputs.
REQ-026 Output register holds value/count stable while valid_o && !ready_i.
REQ-027 Emitted tokens never have count 0; token order equals pixel order; total counts per frame equal pixels per frame.
REQ-028 Runs do not span frames: last_i always terminates the run.
REQ-029 No pixel without last_i is ever flushed; stream idle in RUN holds acc indefinitely.

Reset
REQ-030 Reset: state EMPTY, acc_count_r 0, acc_value_r 0, valid_o 0, rle_value_o 0, rle_count_o 0; ready_o 1 the cycle after reset deasserts.
REQ-031 Reset mid-run/mid-FLUSH discards accumulator and pending token without emission.

Structure
REQ-032 Package rle_pkg holds default widths and the state enum (EMPTY, RUN, FLUSH), shared with rle_decode.
REQ-033 Output register is the single natural sub-module: elastic, width data_width_p+count_width_p; rest is local FSM/counter logic.
REQ-034 Target 120-400 lines RTL.

Verification (data_width_p 2, count_width_p 6)
REQ-035 Pixels 0,0,0,1(last), ready_i=1 -> tokens (0,3),(1,1).
REQ-036 70 pixels of 2, last on 70th -> (2,63),(2,7).
REQ-037 Single pixel 3 with last -> (3,1); state EMPTY after.
REQ-038 Alternating 1,2 pixels, ready_i low 10 cycles -> ready_o drops, valid_o/token held stable, no loss, order preserved.
REQ-039 Five pixels 3, reset, then 0(last) -> only (0,1) emitted.
REQ-040 Pixels 1,1,2(last), ready_i=1 -> (1,2) then (2,1) on consecutive cycles; ready_o low exactly one cycle (FLUSH).

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder/decoder pair.
package rle_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 2;
  localparam int unsigned BUS_WIDTH_DEF   = 8;
  localparam int unsigned COUNT_WIDTH_DEF = BUS_WIDTH_DEF - DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rle_state_e;

endpackage

// File: rtl/rle_encode_if.sv
// Pixel-in / token-out handshake bundle for rle_encode.
// The slave modport is the encoder's view; master is the environment's view.
interface rle_encode_if
  import rle_pkg::*;
#(
  parameter int unsigned data_width_p  = DATA_WIDTH_DEF,
  parameter int unsigned count_width_p = COUNT_WIDTH_DEF
) ();

  logic [data_width_p-1:0]  data_i;
  logic                     last_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [data_width_p-1:0]  rle_value_o;
  logic [count_width_p-1:0] rle_count_o;
  logic                     valid_o;
  logic                     ready_i;

  modport master (
    output data_i, last_i, valid_i, ready_i,
    input  ready_o, rle_value_o, rle_count_o, valid_o
  );

  modport slave (
    input  data_i, last_i, valid_i, ready_i,
    output ready_o, rle_value_o, rle_count_o, valid_o
  );

endinterface

// File: rtl/rle_encode_oreg.sv
// One-entry elastic output register for run tokens. A load always wins;
// otherwise a downstream accept empties the entry. Data holds while stalled.
module rle_encode_oreg #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               i_load,
  input  logic [width_p-1:0] i_data,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [width_p-1:0] o_data
);

  logic               r_valid;
  logic [width_p-1:0] r_data;

  // Token entry: capture on load, drop on downstream accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/rle_encode.sv
// Run-length encoder: collapses consecutive equal pixels into (value, count)
// tokens. Runs saturate at the largest count and never span a frame boundary.
module rle_encode
  import rle_pkg::*;
#(
  parameter int unsigned data_width_p  = DATA_WIDTH_DEF,
  parameter int unsigned bus_width_p   = BUS_WIDTH_DEF,
  parameter int unsigned count_width_p = bus_width_p - data_width_p
) (
  input  logic         clk_i,
  input  logic         reset_i,
  rle_encode_if.slave  bus
);

  localparam int unsigned              TOKEN_W = data_width_p + count_width_p;
  localparam logic [count_width_p-1:0] CMAX    = '1;
  localparam logic [count_width_p-1:0] ONE     = count_width_p'(1);

  rle_state_e                r_state, w_state_nxt;
  logic [data_width_p-1:0]   r_acc_value, w_acc_value_nxt;
  logic [count_width_p-1:0]  r_acc_count, w_acc_count_nxt;

  logic                      w_load;
  logic [data_width_p-1:0]   w_load_value;
  logic [count_width_p-1:0]  w_load_count;
  logic                      w_out_valid;
  logic [TOKEN_W-1:0]        w_out_data;
  logic                      w_can_load;
  logic                      w_in_fire;
  logic                      w_match;

  // The output slot can take a new token if empty or draining this cycle.
  assign w_can_load  = !w_out_valid || bus.ready_i;
  assign bus.ready_o = (r_state != FLUSH) && w_can_load;
  assign w_in_fire   = bus.valid_i && bus.ready_o;
  assign w_match     = (bus.data_i == r_acc_value) && (r_acc_count != CMAX);

  // Accumulator and state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= EMPTY;
      r_acc_value <= '0;
      r_acc_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_value <= w_acc_value_nxt;
      r_acc_count <= w_acc_count_nxt;
    end
  end

  // Next-state, accumulator update and token load decision.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_value_nxt = r_acc_value;
    w_acc_count_nxt = r_acc_count;
    w_load          = 1'b0;
    w_load_value    = r_acc_value;
    w_load_count    = r_acc_count;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          if (bus.last_i) begin
            w_load       = 1'b1;
            w_load_value = bus.data_i;
            w_load_count = ONE;
          end else begin
            w_acc_value_nxt = bus.data_i;
            w_acc_count_nxt = ONE;
            w_state_nxt     = RUN;
          end
        end
      end
      RUN: begin
        if (w_in_fire) begin
          if (w_match) begin
            if (bus.last_i) begin
              w_load          = 1'b1;
              w_load_count    = r_acc_count + ONE;
              w_acc_value_nxt = '0;
              w_acc_count_nxt = '0;
              w_state_nxt     = EMPTY;
            end else begin
              w_acc_count_nxt = r_acc_count + ONE;
            end
          end else begin
            // Old run goes out now; a terminating new pixel waits in FLUSH.
            w_load          = 1'b1;
            w_acc_value_nxt = bus.data_i;
            w_acc_count_nxt = ONE;
            if (bus.last_i) begin
              w_state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (w_can_load) begin
          w_load          = 1'b1;
          w_acc_value_nxt = '0;
          w_acc_count_nxt = '0;
          w_state_nxt     = EMPTY;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  rle_encode_oreg #(
    .width_p (TOKEN_W)
  ) u_oreg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_load  (w_load),
    .i_data  ({w_load_value, w_load_count}),
    .i_ready (bus.ready_i),
    .o_valid (w_out_valid),
    .o_data  (w_out_data)
  );

  assign bus.valid_o                        = w_out_valid;
  assign {bus.rle_value_o, bus.rle_count_o} = w_out_data;

endmodule
